// File: rtl/top_fuzz_core.sv
// -----------------------------------------------------------------------------
// top_fuzz_core
//   Registered mixing datapath for the fuzz harness. Five unsigned operand words
//   are combined each clock. The combinations are add, xor, multiply, rotate,
//   compare, parity and a running 32-bit accumulate. All results are packed into
//   one 119-bit output word with one cycle of latency.
//
// Ports
//   clk    in   1    single clock, rising edge
//   rst    in   1    synchronous active-high reset; clears y and the accumulator
//   wire0  in   19   operand A
//   wire1  in   20   operand B (also the accumulator increment)
//   wire2  in   18   operand C
//   wire3  in   12   operand D; D[3:0] is the rotate amount
//   wire4  in   15   operand E
//   y      out  119  {acc[31:0], prod[26:0], sum[20:0], xr[17:0], rot[18:0], gt, par}
// -----------------------------------------------------------------------------
module top_fuzz_core (
    input  logic         clk,
    input  logic         rst,
    input  logic [18:0]  wire0,
    input  logic [19:0]  wire1,
    input  logic [17:0]  wire2,
    input  logic [11:0]  wire3,
    input  logic [14:0]  wire4,
    output logic [118:0] y
);

    // Rotate left within 19 bits. A doubled copy of the word is shifted and the
    // upper half is taken, so k=0 passes the word through untouched.
    function automatic logic [18:0] rotl19(input logic [18:0] a, input logic [3:0] k);
        logic [37:0] dbl;
        dbl = {a, a} << k;
        return dbl[37:19];
    endfunction

    logic [20:0] w_sum;
    logic [17:0] w_xr;
    logic [26:0] w_prod;
    logic [18:0] w_rot;
    logic        w_gt;
    logic        w_par;
    logic [31:0] w_acc_next;

    logic [31:0]  r_acc_p1;
    logic [118:0] r_y_p1;

    assign w_sum      = {2'b0, wire0} + {1'b0, wire1};
    assign w_xr       = wire2 ^ {6'b0, wire3};
    assign w_prod     = {15'b0, wire3} * {12'b0, wire4};
    assign w_rot      = rotl19(wire0, wire3[3:0]);
    assign w_gt       = (wire0[17:0] > wire2);
    assign w_par      = ^wire1;
    // The packed accumulator field already includes the current wire1 sample.
    assign w_acc_next = r_acc_p1 + {12'b0, wire1};

    // Stage p0 -> p1: combinational results registered into the output word
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc_p1 <= '0;
            r_y_p1   <= '0;
        end else begin
            r_acc_p1 <= w_acc_next;
            r_y_p1   <= {w_acc_next, w_prod, w_sum, w_xr, w_rot, w_gt, w_par};
        end
    end

    assign y = r_y_p1;

endmodule

// File: tb/tb_top_fuzz_core.sv
module tb_top_fuzz_core;

    logic         clk;
    logic         rst;
    logic [18:0]  w0;
    logic [19:0]  w1;
    logic [17:0]  w2;
    logic [11:0]  w3;
    logic [14:0]  w4;
    logic [118:0] y;

    int total;
    int bad;

    logic [31:0]  exp_acc;
    logic [118:0] exp_y;

    top_fuzz_core dut (
        .clk  (clk),
        .rst  (rst),
        .wire0(w0),
        .wire1(w1),
        .wire2(w2),
        .wire3(w3),
        .wire4(w4),
        .y    (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference result from plain arithmetic on the operand values.
    function automatic logic [118:0] model_y(input logic [31:0] acc,
                                             input longint unsigned a,
                                             input longint unsigned b,
                                             input longint unsigned c,
                                             input longint unsigned d,
                                             input longint unsigned e);
        logic [63:0] s, x, p, r;
        logic        gt, par;
        int          k;
        s  = a + b;
        x  = c ^ d;
        p  = d * e;
        k  = int'(d % 16);
        r  = a;
        for (int i = 0; i < k; i++)
            r = ((r * 2) % 524288) | (r / 262144);
        gt  = ((a % 262144) > c);
        par = ($countones(b) % 2) == 1;
        return {acc, p[26:0], s[20:0], x[17:0], r[18:0], gt, par};
    endfunction

    task automatic check(input string name, input logic [118:0] act, input logic [118:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    // One clock: advance the model with the inputs seen at the edge, then
    // compare the DUT output against it just after the edge.
    task automatic step();
        @(posedge clk);
        if (rst) begin
            exp_acc = '0;
            exp_y   = '0;
        end else begin
            exp_acc = exp_acc + {12'b0, w1};
            exp_y   = model_y(exp_acc, w0, w1, w2, w3, w4);
        end
        #1;
        check("y_vs_model", y, exp_y);
    endtask

    task automatic rand_inputs();
        w0 = 19'($urandom);
        w1 = 20'($urandom);
        w2 = 18'($urandom);
        w3 = 12'($urandom);
        w4 = 15'($urandom);
    endtask

    task automatic set_inputs(input logic [18:0] a, input logic [19:0] b, input logic [17:0] c,
                              input logic [11:0] d, input logic [14:0] e);
        w0 = a; w1 = b; w2 = c; w3 = d; w4 = e;
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        exp_acc = '0;
        exp_y   = '0;
        rst     = 1'b1;
        rand_inputs();

        // Reset with random inputs for two edges
        for (int i = 0; i < 2; i++) begin
            step();
            check("reset_zero", y, 119'h0);
            rand_inputs();
        end

        // All-zero inputs out of reset
        rst = 1'b0;
        set_inputs(0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("zero_inputs", y, 119'h0);
        end

        // Small hand-computed vector
        set_inputs(19'd1, 20'd2, 18'd0, 12'd3, 15'd5);
        step();
        check("v3_sum",  119'(y[59:39]),  119'd3);
        check("v3_xr",   119'(y[38:21]),  119'd3);
        check("v3_prod", 119'(y[86:60]),  119'd15);
        check("v3_rot",  119'(y[20:2]),   119'd8);
        check("v3_gt",   119'(y[1]),      119'd1);
        check("v3_par",  119'(y[0]),      119'd1);
        check("v3_acc",  119'(y[118:87]), 119'd2);
        step();
        check("v3_acc2", 119'(y[118:87]), 119'd4);

        // Saturated operands
        set_inputs(19'h7FFFF, 20'hFFFFF, 18'h0, 12'hFFF, 15'h7FFF);
        step();
        check("v4_sum",  119'(y[59:39]), 119'h17FFFE);
        check("v4_prod", 119'(y[86:60]), 119'h7FF7001);
        check("v4_rot",  119'(y[20:2]),  119'h7FFFF);
        check("v4_par",  119'(y[0]),     119'd0);
        check("v4_gt",   119'(y[1]),     119'd1);

        // Accumulator wrap: 4097 * 0xFFFFF = 2^32 + 2^20 - 4097 -> 0x000FEFFF
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 4097; i++) begin
            rand_inputs();
            w1 = 20'hFFFFF;
            step();
        end
        check("acc_wrap", 119'(y[118:87]), 119'h000FEFFF);

        // Mid-operation reset, then restart from zero
        for (int i = 0; i < 5; i++) begin
            rand_inputs();
            step();
        end
        rst = 1'b1;
        rand_inputs();
        step();
        check("mid_reset", y, 119'h0);
        rst = 1'b0;
        rand_inputs();
        w1 = 20'd7;
        step();
        check("restart_acc", 119'(y[118:87]), 119'd7);

        // Rotate amounts swept with a single set bit at the top
        for (int k = 0; k < 16; k++) begin
            set_inputs(19'h40000, 20'd0, 18'd0, 12'(k), 15'd1);
            step();
            check("rot_sweep", 119'(y[20:2]), 119'(19'h40000 >> (19 - k)) | 119'(k == 0 ? 19'h40000 : 19'h0));
        end

        // Random traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            rst = ($urandom_range(0, 19) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
